// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM burst sequencer: burst geometry, wait-counter width, FSM states.
package mem_pkg;

  localparam int BURST_LEN  = 8;
  localparam int BURST_LOG2 = 3;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_FETCH,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with a zero flag; times both the read access and the WE# pulse.
module sram_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_burst_sequencer.sv
// Byte-wide async SRAM controller: one req becomes an aligned 8-byte read or write burst,
// with one registered ready pulse per byte back to the requester.
module sram_burst_sequencer
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 21,
  parameter int READ_WAIT = 2,
  parameter int WE_PULSE  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_address,
  input  logic              req,
  input  logic              req_wren,
  input  logic [7:0]        req_to_mem,
  output logic [7:0]        req_from_mem,
  output logic              req_ready,
  output logic [2:0]        req_offset,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_dq_in,
  output logic [7:0]        sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int                    BASE_W = ADDR_W - BURST_LOG2;
  localparam logic [BURST_LOG2-1:0] LAST_K = BURST_LOG2'(BURST_LEN - 1);

  if (READ_WAIT < 0 || READ_WAIT > 15) begin : g_bad_read_wait
    $error("sram_burst_sequencer: READ_WAIT must be 0..15");
  end
  if (WE_PULSE < 1 || WE_PULSE > 15) begin : g_bad_we_pulse
    $error("sram_burst_sequencer: WE_PULSE must be 1..15");
  end
  if (ADDR_W <= BURST_LOG2) begin : g_bad_addr_w
    $error("sram_burst_sequencer: ADDR_W too small for an 8-byte burst");
  end

  state_t                  state_q, state_d;
  logic [BASE_W-1:0]       base_q, base_d;
  logic [BURST_LOG2-1:0]   k_q, k_d, k_next;
  logic                    ready_q, ready_d;
  logic [2:0]              offset_q, offset_d;
  logic [7:0]              from_mem_q, from_mem_d;
  logic                    busy_q, busy_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [7:0]              dq_out_q, dq_out_d;
  logic                    dq_oe_q, dq_oe_d;
  logic                    ce_n_q, ce_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    we_n_q, we_n_d;

  logic                    cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]        cnt_load_val;

  // The byte offset inside the request address is intentionally discarded.
  logic                    unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_address[BURST_LOG2-1:0];

  assign k_next = k_q + BURST_LOG2'(1);

  sram_wait_counter #(.W(CNT_W)) u_wait (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    k_d          = k_q;
    ready_d      = 1'b0;
    offset_d     = offset_q;
    from_mem_d   = from_mem_q;
    addr_d       = addr_q;
    dq_out_d     = dq_out_q;
    dq_oe_d      = dq_oe_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          base_d = req_address[ADDR_W-1:BURST_LOG2];
          k_d    = '0;
          if (req_wren) begin
            state_d  = S_WR_FETCH;
            ready_d  = 1'b1;
            offset_d = '0;
          end else begin
            state_d      = S_RD_WAIT;
            ce_n_d       = 1'b0;
            oe_n_d       = 1'b0;
            dq_oe_d      = 1'b0;
            addr_d       = {req_address[ADDR_W-1:BURST_LOG2], {BURST_LOG2{1'b0}}};
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(READ_WAIT);
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_zero) begin
          from_mem_d = sram_dq_in;
          ready_d    = 1'b1;
          offset_d   = k_q;
          if (k_q == LAST_K) begin
            state_d = S_IDLE;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
          end else begin
            k_d          = k_next;
            addr_d       = {base_q, k_next};
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(READ_WAIT);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_WR_FETCH: begin
        state_d = S_WR_SETUP;
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b1;
        dq_oe_d = 1'b1;
        addr_d  = {base_q, k_q};
      end
      S_WR_SETUP: begin
        // The requester's byte for this offset is only valid now, one cycle after the pulse.
        dq_out_d     = req_to_mem;
        we_n_d       = 1'b0;
        state_d      = S_WR_PULSE;
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(WE_PULSE - 1);
      end
      S_WR_PULSE: begin
        if (cnt_zero) begin
          we_n_d  = 1'b1;
          state_d = S_WR_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_WR_HOLD: begin
        if (k_q == LAST_K) begin
          state_d = S_IDLE;
          dq_oe_d = 1'b0;
          ce_n_d  = 1'b1;
        end else begin
          k_d      = k_next;
          state_d  = S_WR_FETCH;
          ready_d  = 1'b1;
          offset_d = k_next;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      k_q        <= '0;
      ready_q    <= 1'b0;
      offset_q   <= '0;
      from_mem_q <= '0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      k_q        <= k_d;
      ready_q    <= ready_d;
      offset_q   <= offset_d;
      from_mem_q <= from_mem_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
    end
  end

  assign req_ready    = ready_q;
  assign req_offset   = offset_q;
  assign req_from_mem = from_mem_q;
  assign busy         = busy_q;
  assign sram_addr    = addr_q;
  assign sram_dq_out  = dq_out_q;
  assign sram_dq_oe   = dq_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;

endmodule
